// File: rtl/miss_reg_slave.sv
// ---------------------------------------------------------------------------
// miss_reg_slave
//   AXI-Lite register slave that records TLB-miss events and lets software
//   request a replay. The first miss while idle is captured (address, count)
//   and raises tlb_miss. Later misses only set an overflow flag. A write of
//   bit 8 to CTRL (byte lane 1 enabled) clears pending/overflow and pulses
//   replay_req for one cycle.
//
// Ports
//   clk, aresetn            clock, synchronous active-low reset
//   miss_valid, miss_vaddr  one-cycle miss event with its 48-bit address
//   tlb_miss                level: a captured miss is pending
//   replay_req              one-cycle pulse on a replay-clearing CTRL write
//   s00_axi_*               AXI-Lite slave (AW, W, B, AR, R channels)
//
// Register map (offset = addr[7:0])
//   0x00 CTRL        {63'd0, pending}             write bit 8 (lane 1) = replay
//   0x08 STATUS      {62'd0, overflow, pending}   read only
//   0x20 MISS_VADDR  {16'd0, vaddr[47:0]}         read only
//   0x28 MISS_COUNT  {32'd0, count[31:0]}         read only
// ---------------------------------------------------------------------------
module miss_reg_slave #(
  parameter int C_S00_AXI_ADDR_WIDTH = 64,
  parameter int C_S00_AXI_DATA_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                aresetn,
  input  logic                                miss_valid,
  input  logic [47:0]                         miss_vaddr,
  output logic                                tlb_miss,
  output logic                                replay_req,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_VADDR  = 8'h20;
  localparam logic [7:0] ADDR_COUNT  = 8'h28;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic {RD_ADDR, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  // Write-channel capture
  logic       aw_got, w_got;
  logic [7:0] wr_addr;
  logic       wr_strb1, wr_data8;

  // Miss bookkeeping
  logic        pending_q, overflow_q;
  logic [47:0] vaddr_q;
  logic [31:0] count_q;
  logic        pending_d, overflow_d;
  logic [47:0] vaddr_d;
  logic [31:0] count_d;

  // Handshakes and the effective write beat (latched value or same-cycle input)
  logic       aw_hs, w_hs, ar_hs;
  logic       wr_fire, wr_is_ctrl, do_clear;
  logic [7:0] eff_addr;
  logic       eff_strb1, eff_data8;

  logic [C_S00_AXI_DATA_WIDTH-1:0] rd_word;
  logic                            rd_err;

  assign tlb_miss = pending_q;

  assign aw_hs     = s00_axi_awvalid && s00_axi_awready;
  assign w_hs      = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs     = s00_axi_arvalid && s00_axi_arready;
  assign eff_addr  = aw_got ? wr_addr  : s00_axi_awaddr[7:0];
  assign eff_strb1 = w_got  ? wr_strb1 : s00_axi_wstrb[1];
  assign eff_data8 = w_got  ? wr_data8 : s00_axi_wdata[8];

  // The write commits on the edge where both halves are (or become) present.
  assign wr_fire    = (wr_state == WR_COLLECT) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_is_ctrl = (eff_addr == ADDR_CTRL);
  assign do_clear   = wr_fire && wr_is_ctrl && eff_strb1 && eff_data8;

  // Write FSM: next state and ready outputs. Readies are gated by aresetn so
  // they read 0 throughout reset and 1 as soon as it is released.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    wr_next         = wr_state;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    case (wr_state)
      WR_COLLECT: begin
        s00_axi_awready = aresetn && !aw_got;
        s00_axi_wready  = aresetn && !w_got;
        if (wr_fire) wr_next = WR_RESP;
      end
      WR_RESP: begin
        if (s00_axi_bready) wr_next = WR_COLLECT;
      end
      default: wr_next = WR_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      wr_state       <= WR_COLLECT;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      wr_addr        <= '0;
      wr_strb1       <= 1'b0;
      wr_data8       <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (wr_state == WR_COLLECT) begin
        if (aw_hs) begin
          aw_got  <= 1'b1;
          wr_addr <= s00_axi_awaddr[7:0];
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          wr_strb1 <= s00_axi_wstrb[1];
          wr_data8 <= s00_axi_wdata[8];
        end
        if (wr_fire) begin
          s00_axi_bvalid <= 1'b1;
          s00_axi_bresp  <= wr_is_ctrl ? RESP_OKAY : RESP_SLVERR;
        end
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
        aw_got         <= 1'b0;
        w_got          <= 1'b0;
      end
    end
  end

  // Miss state update: a replay clear is applied before a same-cycle miss.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    vaddr_d    = vaddr_q;
    count_d    = count_q;
    if (do_clear) begin
      pending_d  = 1'b0;
      overflow_d = 1'b0;
    end
    if (miss_valid) begin
      if (!pending_d) begin
        vaddr_d   = miss_vaddr;
        pending_d = 1'b1;
        count_d   = count_q + 32'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      vaddr_q    <= '0;
      count_q    <= '0;
      replay_req <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      vaddr_q    <= vaddr_d;
      count_q    <= count_d;
      replay_req <= do_clear;
    end
  end

  // Read decode from the current register state.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (s00_axi_araddr[7:0])
      ADDR_CTRL:   rd_word[0]    = pending_q;
      ADDR_STATUS: rd_word[1:0]  = {overflow_q, pending_q};
      ADDR_VADDR:  rd_word[47:0] = vaddr_q;
      ADDR_COUNT:  rd_word[31:0] = count_q;
      default:     rd_err        = 1'b1;
    endcase
  end

  always_comb begin
    rd_next         = rd_state;
    s00_axi_arready = 1'b0;
    case (rd_state)
      RD_ADDR: begin
        s00_axi_arready = aresetn;
        if (ar_hs) rd_next = RD_DATA;
      end
      RD_DATA: begin
        if (s00_axi_rready) rd_next = RD_ADDR;
      end
      default: rd_next = RD_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rd_state       <= RD_ADDR;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
        s00_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rd_state == RD_DATA && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  // Address bits above the decode window, prot and the unused data/strobe
  // bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr, s00_axi_araddr, s00_axi_awprot,
                         s00_axi_arprot, s00_axi_wdata, s00_axi_wstrb};

endmodule

// File: doc/miss_reg_slave.md
MISS_REG_SLAVE -- requirements
Module: miss_reg_slave

Interface
REQ-001 The module SHALL have these parameters: C_S00_AXI_ADDR_WIDTH, default 64, AXI-Lite address width; C_S00_AXI_DATA_WIDTH, default 64, AXI-Lite data width.
REQ-002 The module SHALL have these ports:
- clk  in  1  sole clock
- aresetn  in  1  synchronous active-low reset
- miss_valid  in  1  one-cycle TLB-miss event
- miss_vaddr  in  48  virtual address of the miss, valid with miss_valid
- tlb_miss  out  1  miss pending (level)
- replay_req  out  1  one-cycle replay pulse
- s00_axi_aw{addr,prot,valid}/awready  in/in/in/out  ADDR/3/1/1  write address
- s00_axi_w{data,strb,valid}/wready  in/in/in/out  DATA/DATA/8/1/1  write data
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s00_axi_ar{addr,prot,valid}/arready  in/in/in/out  ADDR/3/1/1  read address
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA/2/1/1  read data
REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-low, aresetn.

Function
REQ-004 Decode SHALL use awaddr/araddr[7:0] only; upper bits and prot SHALL be ignored.
REQ-005 Register map:
- 0x00 CTRL: read returns {63'd0, pending}.
- 0x08 STATUS (RO): {62'd0, overflow, pending}.
- 0x20 MISS_VADDR (RO): {16'd0, vaddr[47:0]}.
- 0x28 MISS_COUNT (RO): {32'd0, count[31:0]}.
REQ-006 A write to CTRL with wstrb[1]=1 and wdata[8]=1 SHALL clear pending and overflow and pulse replay_req high for exactly one cycle; any other CTRL write SHALL have no effect; both SHALL return bresp OKAY (2'b00).
REQ-007 Writes to any other offset SHALL have no effect and SHALL return bresp SLVERR (2'b10).
REQ-008 Reads of an unmapped offset SHALL return rdata 0 with rresp SLVERR; mapped reads SHALL return rresp OKAY.
REQ-009 miss_valid with pending=0 SHALL capture miss_vaddr, set pending, and increment count (wraps 0xFFFFFFFF->0).
REQ-010 miss_valid with pending=1 SHALL set overflow; vaddr and count SHALL be unchanged.
REQ-011 If a replay-clearing write takes effect in the same cycle as miss_valid, the clear SHALL apply first: the new miss is captured, pending=1, count increments, overflow=0.
REQ-012 tlb_miss SHALL equal the registered pending bit.
REQ-013 Write FSM states: WR_COLLECT and WR_RESP.
REQ-014 In WR_COLLECT, awready = !aw_got and wready = !w_got; AW and W SHALL be accepted in either order or in the same cycle, and each SHALL be latched on its handshake.
REQ-015 On the edge where both aw_got and w_got are true (including a same-cycle capture), the write SHALL take effect, bvalid SHALL rise, and the FSM SHALL enter WR_RESP.
REQ-016 In WR_RESP, awready=wready=0; bvalid and bresp SHALL hold until bready; on the handshake, bvalid->0, aw_got/w_got cleared, FSM->WR_COLLECT.
REQ-017 No second AW or W SHALL be accepted before the B handshake completes, so a master holding valid extra cycles is tolerated.
REQ-018 Read FSM states: RD_ADDR (arready=1) and RD_DATA (arready=0).
REQ-019 On the AR handshake, rdata/rresp SHALL be registered from current register state, rvalid SHALL rise the next cycle, and the FSM SHALL enter RD_DATA.
REQ-020 rvalid/rdata SHALL hold until rready, then rvalid->0 and the FSM SHALL return to RD_ADDR.
REQ-021 The read and write paths SHALL be independent and SHALL be able to run concurrently.

Reset
REQ-022 While aresetn=0 on a clock edge: all outputs 0 (awready, wready and arready included), bresp=rresp=0, pending/overflow/vaddr/count=0, both FSMs in their idle states.
REQ-023 awready, wready and arready SHALL be 1 in the first cycle after reset release.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no register side effect and no B/R beat.

Verification
REQ-025 miss_valid, vaddr=0x1234_5678_9ABC -> tlb_miss=1 next cycle; read 0x20 -> rdata 0x0000_1234_5678_9ABC, OKAY; read 0x28 -> 1.
REQ-026 Second miss_valid while pending -> STATUS=0x3; vaddr and count unchanged.
REQ-027 AW(0x00) 3 cycles before W(0x100, strb 0xFF), master holds awvalid 2 extra cycles -> one write, replay_req one cycle, tlb_miss=0, single B OKAY.
REQ-028 Write to 0x20 -> SLVERR, vaddr unchanged; read 0x18 -> rdata 0, SLVERR.
REQ-029 Replay write lands on same edge as miss_valid(0xABC) -> pending=1, vaddr=0xABC, count+1, overflow=0.
REQ-030 bready held low 10 cycles, concurrent read -> bvalid held, read completes, no new AW accepted; reset mid-R -> rvalid=0, state idle.
